kernel_launcher: RTL and testbench
==================================

Name: kernel_launcher

Overview:
- Control stage directly upstream and downstream of the HLS kernel's start/done interface (main_minimal_interface).
- Issues single-cycle start pulses to the kernel, waits for done, and captures the return value.
- Measures run latency in clock cycles and guards against a hung kernel with a timeout.
- Presents each run result to downstream logic (status/UART/XVC reporter) over a valid/ready handshake.

Parameters:
- RET_W, 32: width of kernel return value.
- CNT_W, 32: width of cycle and run counters.
- TIMEOUT_CYCLES, 1000000: cycles allowed in WAIT before abort; 0 disables timeout.
- AUTO_RELAUNCH, 0: if 1, a new run starts after every consumed result regardless of `launch`.

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- launch  in  1  level request to run the kernel
- kernel_start  out  1  one-cycle start pulse to kernel start_port
- kernel_done  in  1  one-cycle done pulse from kernel done_port
- kernel_return  in  RET_W  kernel return_port; valid only in the kernel_done cycle
- result  out  RET_W  captured return value
- result_cycles  out  CNT_W  latency of the captured run
- result_timeout  out  1  1 = run aborted by timeout
- result_valid  out  1  result fields valid
- result_ready  in  1  downstream accepts result
- busy  out  1  high in START, WAIT, or HOLD
- run_count  out  CNT_W  completed runs (done or timeout)
- stray_done  out  1  sticky: kernel_done seen outside WAIT

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is synchronous and active-high; when sampled high, all outputs and registers are 0 the next cycle and the state is IDLE.
  - Reset during any state (including WAIT) aborts with no result; a late kernel_done after reset sets stray_done.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - Outputs kernel_start=0, result_valid=0.
  - launch=1 (or AUTO_RELAUNCH=1 after the first launch) -> START.
- START:
  - Exactly one cycle with kernel_start=1.
  - Cycle counter cleared to 0.
  - -> WAIT unconditionally.
- WAIT:
  - Counter increments by 1 each cycle it is in WAIT and saturates at all-ones.
  - On kernel_done=1: result<=kernel_return, result_cycles<=counter+1 (saturating), result_timeout<=0, run_count+1 (wraps) -> HOLD.
  - Latency is therefore the number of cycles from the cycle after kernel_start up to and including the done cycle.
  - If TIMEOUT_CYCLES!=0 and counter+1==TIMEOUT_CYCLES without done: result<=0, result_cycles<=TIMEOUT_CYCLES, result_timeout<=1, run_count+1 -> HOLD.
  - If done and timeout occur in the same cycle, done wins.
- HOLD:
  - result_valid=1; result fields stable until the handshake.
  - Handshake is result_valid&&result_ready. On handshake:
    - launch=1 or AUTO_RELAUNCH=1 -> START in the next cycle.
    - Otherwise -> IDLE.
  - result_valid drops the cycle after the handshake unless a new result is ready; no new result appears before the next START/WAIT.
- Ignored inputs:
  - launch is ignored in START, WAIT, and HOLD (no queuing).
  - Deasserting launch mid-run does not abort the run.
- stray_done:
  - Set by kernel_done=1 in IDLE, START, or HOLD, including a late done after a timeout.
  - Cleared only by reset.
  - A stray done never alters result or state.
- busy = (state != IDLE), registered with the state.
- Counter arithmetic is unsigned CNT_W bits; only run_count wraps, the cycle counter saturates.

Test Plan:
- Basic run:
  - Stimulus: launch=1 one cycle; kernel model asserts done 5 cycles after start, return=0xDEADBEEF; result_ready=1.
  - Required: kernel_start high exactly 1 cycle; result_valid for 1 cycle with result=0xDEADBEEF, result_cycles=5, result_timeout=0; run_count=1; busy back to 0.
- Backpressure:
  - Stimulus: same run with result_ready=0 for 10 cycles, then 1.
  - Required: result_valid held 11 cycles with fields unchanged; one handshake; no second kernel_start while launch=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; kernel never asserts done.
  - Required: result_valid with result_timeout=1, result=0, result_cycles=16; a later kernel_done sets stray_done=1 and leaves state unchanged.
- Back-to-back:
  - Stimulus: launch held 1; kernel latencies 3, 7, 1.
  - Required: three runs, each kernel_start one cycle after the previous handshake; result_cycles 3, 7, 1; run_count=3.
- Reset mid-run:
  - Stimulus: reset for 1 cycle in WAIT at counter=4, then the kernel's pending done arrives.
  - Required: all outputs 0 after reset, no result_valid, stray_done=1, state IDLE.
- Done/timeout collision:
  - Stimulus: TIMEOUT_CYCLES=8; done asserted exactly at the timeout cycle with return=0x5.
  - Required: result=0x5, result_cycles=8, result_timeout=0.

Source files
------------

// File: rtl/kernel_launcher.sv
// kernel_launcher: control stage around an HLS kernel's start/done interface.
//
// Issues a single-cycle start pulse, waits for the kernel's done pulse (or a
// timeout), measures run latency in cycles and presents each run result
// downstream over a valid/ready handshake.
//
// Ports:
//   clock          - single system clock
//   reset          - synchronous, active-high reset
//   launch         - level request to run the kernel (sampled in IDLE/HOLD only)
//   kernel_start   - one-cycle start pulse to the kernel
//   kernel_done    - one-cycle done pulse from the kernel
//   kernel_return  - kernel return value, valid only with kernel_done
//   result         - captured return value (0 on timeout)
//   result_cycles  - latency of the captured run
//   result_timeout - 1 when the run was aborted by timeout
//   result_valid   - result fields valid (HOLD)
//   result_ready   - downstream accepts the result
//   busy           - high in START, WAIT or HOLD
//   run_count      - completed runs (done or timeout), wraps
//   stray_done     - sticky: kernel_done seen outside WAIT, cleared by reset
module kernel_launcher #(
  parameter int unsigned RET_W          = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          AUTO_RELAUNCH  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             launch,
  output logic             kernel_start,
  input  logic             kernel_done,
  input  logic [RET_W-1:0] kernel_return,
  output logic [RET_W-1:0] result,
  output logic [CNT_W-1:0] result_cycles,
  output logic             result_timeout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic [CNT_W-1:0] run_count,
  output logic             stray_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

  // A timeout wider than the counter can never be reached: the counter
  // saturates at all-ones first, so treat it as disabled rather than letting
  // the truncated value fire early.
  localparam bit TimeoutFits = ((64'(TIMEOUT_CYCLES) >> CNT_W) == 64'd0);
  localparam bit TimeoutEn   = (TIMEOUT_CYCLES != 0) && TimeoutFits;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] run_count_q, run_count_d;
  logic             stray_q, stray_d;
  logic             armed_q, armed_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // Saturating count of WAIT cycles including the current one.
  assign cnt_inc     = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;
  assign timeout_hit = TimeoutEn && (cnt_inc == TimeoutVal);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    cycles_d    = cycles_q;
    timeout_d   = timeout_q;
    run_count_d = run_count_q;
    armed_d     = armed_q;
    // Any done outside WAIT is stray; it never touches state or result.
    stray_d     = stray_q | (kernel_done && (state_q != StWait));

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          armed_d = 1'b1;
        end
        // Auto relaunch only kicks in once a first explicit launch was seen.
        if (launch || (AUTO_RELAUNCH && armed_q)) begin
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done has priority over a timeout landing in the same cycle.
        if (kernel_done) begin
          result_d    = kernel_return;
          cycles_d    = cnt_inc;
          timeout_d   = 1'b0;
          run_count_d = run_count_q + 1'b1;
          state_d     = StHold;
        end else if (timeout_hit) begin
          result_d    = '0;
          cycles_d    = TimeoutVal;
          timeout_d   = 1'b1;
          run_count_d = run_count_q + 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHold: begin
        if (result_ready) begin
          state_d = (launch || AUTO_RELAUNCH) ? StStart : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      result_q    <= '0;
      cycles_q    <= '0;
      timeout_q   <= 1'b0;
      run_count_q <= '0;
      stray_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      cycles_q    <= cycles_d;
      timeout_q   <= timeout_d;
      run_count_q <= run_count_d;
      stray_q     <= stray_d;
      armed_q     <= armed_d;
    end
  end

  assign kernel_start   = (state_q == StStart);
  assign result_valid   = (state_q == StHold);
  assign busy           = (state_q != StIdle);
  assign result         = result_q;
  assign result_cycles  = cycles_q;
  assign result_timeout = timeout_q;
  assign run_count      = run_count_q;
  assign stray_done     = stray_q;

endmodule

// File: tb/tb_kernel_launcher.sv
// Self-checking bench for kernel_launcher. A transaction-level model predicts
// each run's outcome (return value or timeout, latency, run count, sticky
// stray flag) from the chosen kernel latency; directed runs cover the basic,
// backpressure, timeout, collision, reset and back-to-back cases, followed by
// randomized runs.
module tb_kernel_launcher;

  localparam int unsigned RET_W = 32;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TMO   = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             launch;
  logic             kernel_start;
  logic             kernel_done;
  logic [RET_W-1:0] kernel_return;
  logic [RET_W-1:0] result;
  logic [CNT_W-1:0] result_cycles;
  logic             result_timeout;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic [CNT_W-1:0] run_count;
  logic             stray_done;

  int n_vec = 0;
  int n_err = 0;
  int exp_runs = 0;
  bit exp_stray = 1'b0;

  kernel_launcher #(
    .RET_W         (RET_W),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TMO),
    .AUTO_RELAUNCH (1'b0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .launch        (launch),
    .kernel_start  (kernel_start),
    .kernel_done   (kernel_done),
    .kernel_return (kernel_return),
    .result        (result),
    .result_cycles (result_cycles),
    .result_timeout(result_timeout),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .busy          (busy),
    .run_count     (run_count),
    .stray_done    (stray_done)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_result"}, 64'(result), 64'd0);
    check_val({tag, "_cycles"}, 64'(result_cycles), 64'd0);
    check_val({tag, "_tmo"}, 64'(result_timeout), 64'd0);
    check_val({tag, "_valid"}, 64'(result_valid), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_start"}, 64'(kernel_start), 64'd0);
    check_val({tag, "_runs"}, 64'(run_count), 64'd0);
    check_val({tag, "_stray"}, 64'(stray_done), 64'd0);
  endtask

  // One kernel run. lat > TMO means the kernel never answers. started=1 means
  // the previous handshake already relaunched, so START is being sampled now.
  task automatic run_txn(input int lat, input logic [RET_W-1:0] ret, input int stall,
                         input bit hold_launch, input bit started, input bit late_done);
    int exit_k;
    int k;
    logic [RET_W-1:0] exp_res;
    logic [CNT_W-1:0] exp_cyc;
    bit exp_tmo;
    if (lat <= int'(TMO)) begin
      exit_k  = lat;
      exp_res = ret;
      exp_cyc = CNT_W'(lat);
      exp_tmo = 1'b0;
    end else begin
      exit_k  = int'(TMO);
      exp_res = '0;
      exp_cyc = CNT_W'(TMO);
      exp_tmo = 1'b1;
    end
    if (!started) begin
      launch = 1'b1;
      step();
    end
    check_val("start_pulse", 64'(kernel_start), 64'd1);
    check_val("start_busy", 64'(busy), 64'd1);
    kernel_done = 1'b0;
    launch = 1'($urandom_range(0, 1));
    step();
    check_val("start_one_cycle", 64'(kernel_start), 64'd0);
    k = 0;
    while (!result_valid && k < 64) begin
      k++;
      kernel_done   = (k == lat);
      kernel_return = (k == lat) ? ret : RET_W'($urandom());
      launch        = 1'($urandom_range(0, 1));
      step();
      kernel_done = 1'b0;
    end
    if (result_valid) exp_runs++;
    check_val("exit_cycle", 64'(k), 64'(exit_k));
    check_val("result", 64'(result), 64'(exp_res));
    check_val("result_cycles", 64'(result_cycles), 64'(exp_cyc));
    check_val("result_timeout", 64'(result_timeout), 64'(exp_tmo));
    check_val("run_count", 64'(run_count), 64'(exp_runs));
    result_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      launch        = 1'($urandom_range(0, 1));
      kernel_done   = late_done && (i == 0);
      kernel_return = RET_W'($urandom());
      if (kernel_done) exp_stray = 1'b1;
      step();
      kernel_done = 1'b0;
      check_val("hold_valid", 64'(result_valid), 64'd1);
      check_val("hold_result", 64'(result), 64'(exp_res));
      check_val("hold_cycles", 64'(result_cycles), 64'(exp_cyc));
      check_val("hold_tmo", 64'(result_timeout), 64'(exp_tmo));
      check_val("hold_start", 64'(kernel_start), 64'd0);
    end
    result_ready = 1'b1;
    launch = hold_launch;
    step();
    result_ready = 1'b0;
    check_val("post_hs_valid", 64'(result_valid), 64'd0);
    check_val("post_hs_start", 64'(kernel_start), 64'(hold_launch));
    check_val("post_hs_busy", 64'(busy), 64'(hold_launch));
    check_val("post_hs_stray", 64'(stray_done), 64'(exp_stray));
    if (!hold_launch) begin
      step();
      check_val("idle_no_start", 64'(kernel_start), 64'd0);
      check_val("idle_runs", 64'(run_count), 64'(exp_runs));
    end
  endtask

  initial begin
    bit prev_hold;
    reset = 1'b1;
    launch = 1'b0;
    kernel_done = 1'b0;
    kernel_return = '0;
    result_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    check_all_zero("reset");

    // Basic run, backpressure, timeout with late done, done/timeout collision.
    run_txn(5, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
    run_txn(5, 32'hDEADBEEF, 10, 1'b0, 1'b0, 1'b0);
    run_txn(100, 32'h12345678, 3, 1'b0, 1'b0, 1'b1);
    check_val("late_done_stray", 64'(stray_done), 64'd1);
    run_txn(int'(TMO), 32'h5, 0, 1'b0, 1'b0, 1'b0);

    // Reset in WAIT with the counter at 4, then the pending done arrives.
    launch = 1'b1;
    step();
    launch = 1'b0;
    repeat (5) step();
    check_val("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_runs = 0;
    exp_stray = 1'b0;
    check_all_zero("mid_reset");
    kernel_done = 1'b1;
    kernel_return = 32'hCAFEF00D;
    step();
    kernel_done = 1'b0;
    exp_stray = 1'b1;
    check_val("rst_stray", 64'(stray_done), 64'd1);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_valid", 64'(result_valid), 64'd0);
    check_val("rst_result", 64'(result), 64'd0);
    step();
    check_val("rst_idle", 64'(busy), 64'd0);

    // Back-to-back with launch held.
    run_txn(3, 32'h1111, 0, 1'b1, 1'b0, 1'b0);
    run_txn(7, 32'h2222, 0, 1'b1, 1'b1, 1'b0);
    run_txn(1, 32'h3333, 0, 1'b0, 1'b1, 1'b0);
    check_val("b2b_runs", 64'(run_count), 64'd3);

    // Randomized runs.
    prev_hold = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      if (!prev_hold && ($urandom_range(0, 4) == 0)) begin
        kernel_done = 1'b1;
        step();
        kernel_done = 1'b0;
        exp_stray = 1'b1;
        check_val("idle_stray", 64'(stray_done), 64'd1);
        check_val("idle_stray_busy", 64'(busy), 64'd0);
      end
      run_txn($urandom_range(1, 24), RET_W'($urandom()), $urandom_range(0, 4), hold,
              prev_hold, ($urandom_range(0, 3) == 0));
      prev_hold = hold;
    end
    if (prev_hold) run_txn(2, 32'hA5A5, 0, 1'b0, 1'b1, 1'b0);
    check_val("final_runs", 64'(run_count), 64'(exp_runs));
    check_val("final_stray", 64'(stray_done), 64'(exp_stray));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
